// File: rtl/gr8ram_pkg.sv
// Shared constants for the GR8RAM DRAM path: owner codes, Apple bus states, refresh defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gr8ram_pkg;

    // DRAM owner encoding, as presented on the Owner output
    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_REF  = 2'b10;
    localparam logic [1:0] OWN_COPY = 2'b11;

    // Apple bus states; 0 means the bus phase tracker is not yet synced
    localparam logic [2:0] S_UNSYNC = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    // Refresh defaults
    localparam int REF_PERIOD_DEF   = 13;
    localparam int REF_MAX_PEND_DEF = 4;

    // While unsynced, one refresh tick is synthesised every seven C7M cycles
    localparam logic [2:0] UNSYNC_DIV_LAST = 3'd6;

    // Access currently holding (or about to hold) the DRAM
    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_REF,
        ACC_COPY,
        ACC_RD,
        ACC_WR
    } acc_t;

    function automatic logic [1:0] owner_of(input acc_t a);
        case (a)
            ACC_REF:        owner_of = OWN_REF;
            ACC_COPY:       owner_of = OWN_COPY;
            ACC_RD, ACC_WR: owner_of = OWN_CPU;
            default:        owner_of = OWN_IDLE;
        endcase
    endfunction

    // {CAS1, CAS0} for a single-bank access
    function automatic logic [1:0] cas_sel(input logic bank);
        cas_sel = bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dram_ref_ctr.sv
// Refresh period counter plus saturating count of refreshes still owed.
// Latency: count updates one C7M edge after tick/dec; pend_nz follows the count directly.
// Backpressure: none; excess requests beyond REF_MAX_PEND are dropped by saturation.
module dram_ref_ctr
    import gr8ram_pkg::*;
#(
    parameter int REF_PERIOD   = REF_PERIOD_DEF,
    parameter int REF_MAX_PEND = REF_MAX_PEND_DEF
) (
    input  logic                                  C7M,
    input  logic                                  RES,
    input  logic                                  tick,
    input  logic                                  dec,
    output logic                                  pend_nz,
    output logic [$clog2(REF_MAX_PEND + 1)-1:0]   pend_cnt
);
    localparam int CW = $clog2(REF_PERIOD);
    localparam int PW = $clog2(REF_MAX_PEND + 1);

    logic [CW-1:0] period_cnt;
    logic          wrap;

    assign wrap    = tick && (period_cnt == CW'(REF_PERIOD - 1));
    assign pend_nz = (pend_cnt != '0);

    // Count bus-cycle ticks, wrapping once per refresh period
    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= wrap ? '0 : period_cnt + CW'(1);
        end
    end

    // A simultaneous wrap and completed refresh cancel each other out
    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            pend_cnt <= '0;
        end else if (wrap && !dec) begin
            if (pend_cnt != PW'(REF_MAX_PEND)) pend_cnt <= pend_cnt + PW'(1);
        end else if (dec && !wrap) begin
            if (pend_cnt != '0) pend_cnt <= pend_cnt - PW'(1);
        end
    end

endmodule

// File: rtl/dram_sched.sv
// DRAM strobe scheduler: refresh/copy in S1..S3, reserved CPU window in S4..S7 (copy port under DRAM_SCHED_COPY_EN).
// Latency: strobes are registered; the pattern for the bus state sampled on an edge appears right after it.
// Backpressure: CPU never waits; copy holds CopyReq until a one-cycle CopyAck, refresh accrues as pending count.
module dram_sched
    import gr8ram_pkg::*;
#(
    parameter int REF_PERIOD   = REF_PERIOD_DEF,
    parameter int REF_MAX_PEND = REF_MAX_PEND_DEF
) (
    input  logic       C7M,
    input  logic       RES,
    input  logic [2:0] S,
    input  logic       CpuReq,
    input  logic       CpuWr,
    input  logic       CpuBank,
    input  logic       CopyReq,
    input  logic       CopyBank,
    output logic       CopyAck,
    output logic       RAS,
    output logic       CAS0,
    output logic       CAS1,
    output logic       CASel,
    output logic [1:0] Owner,
    output logic       RefPend
);
    localparam int PW = $clog2(REF_MAX_PEND + 1);

    acc_t          acc, acc_n;
    logic          bank, bank_n;
    logic [2:0]    prev_s;
    logic [2:0]    udiv;
    logic [1:0]    cas_q, cas_n;
    logic          ras_n, casel_n, ack_n, dec, tick, abort;
    logic          copy_req, copy_bank;
    logic [PW-1:0] pend_cnt;
    logic          unused_ok;

`ifdef DRAM_SCHED_COPY_EN
    assign copy_req  = CopyReq;
    assign copy_bank = CopyBank;
    assign unused_ok = ^pend_cnt;
`else
    // Background window serves refresh only; copy port is inert
    assign copy_req  = 1'b0;
    assign copy_bank = 1'b0;
    assign unused_ok = ^{pend_cnt, CopyReq, CopyBank};
`endif

    assign CAS0 = cas_q[0];
    assign CAS1 = cas_q[1];

    // Refresh keeps accruing while unsynced via a divide-by-7 stand-in for S3
    assign tick  = (S == S3) || ((S == S_UNSYNC) && (udiv == UNSYNC_DIV_LAST));
    // Losing sync, or an S1 that interrupts a live access, kills the access
    assign abort = (S == S_UNSYNC) || ((S == S1) && (prev_s != S7) && (acc != ACC_IDLE));

    dram_ref_ctr #(
        .REF_PERIOD   (REF_PERIOD),
        .REF_MAX_PEND (REF_MAX_PEND)
    ) u_ref (
        .C7M      (C7M),
        .RES      (RES),
        .tick     (tick),
        .dec      (dec),
        .pend_nz  (RefPend),
        .pend_cnt (pend_cnt)
    );

    // Unsynced bus-cycle divider
    always_ff @(posedge C7M or posedge RES) begin
        if (RES)                    udiv <= '0;
        else if (S != S_UNSYNC)     udiv <= '0;
        else if (udiv == UNSYNC_DIV_LAST) udiv <= '0;
        else                        udiv <= udiv + 3'd1;
    end

    // Next access and strobe pattern from the sampled bus state
    always_comb begin
        acc_n   = acc;
        bank_n  = bank;
        ras_n   = 1'b0;
        cas_n   = 2'b00;
        casel_n = 1'b0;
        ack_n   = 1'b0;
        dec     = 1'b0;
        if (abort) begin
            acc_n = ACC_IDLE;
        end else begin
            case (S)
                S1: begin
                    if (RefPend) begin
                        acc_n = ACC_REF;
                        cas_n = 2'b11;
                    end else if (copy_req) begin
                        acc_n  = ACC_COPY;
                        bank_n = copy_bank;
                        ras_n  = 1'b1;
                    end else begin
                        acc_n = ACC_IDLE;
                    end
                end
                S2, S3: begin
                    if (acc == ACC_REF) begin
                        ras_n = 1'b1;
                        cas_n = 2'b11;
                        dec   = (S == S3);
                    end else if (acc == ACC_COPY) begin
                        ras_n   = 1'b1;
                        casel_n = 1'b1;
                        cas_n   = cas_sel(bank);
                        ack_n   = (S == S3);
                    end
                end
                S4: begin
                    if (CpuReq) begin
                        acc_n  = CpuWr ? ACC_WR : ACC_RD;
                        bank_n = CpuBank;
                    end else begin
                        acc_n = ACC_IDLE;
                    end
                end
                S5: begin
                    if (acc == ACC_RD) begin
                        ras_n   = 1'b1;
                        casel_n = 1'b1;
                    end
                end
                S6: begin
                    if (acc == ACC_RD || acc == ACC_WR) begin
                        ras_n   = 1'b1;
                        casel_n = 1'b1;
                        cas_n   = (acc == ACC_RD) ? cas_sel(bank) : 2'b00;
                    end
                end
                S7: begin
                    if (acc == ACC_RD || acc == ACC_WR) begin
                        ras_n   = 1'b1;
                        casel_n = 1'b1;
                        cas_n   = cas_sel(bank);
                    end
                end
                default: ;
            endcase
        end
    end

    // Access state and registered strobes; Owner is idle whenever no strobe is driven
    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            acc     <= ACC_IDLE;
            bank    <= 1'b0;
            prev_s  <= S_UNSYNC;
            RAS     <= 1'b0;
            cas_q   <= 2'b00;
            CASel   <= 1'b0;
            CopyAck <= 1'b0;
            Owner   <= OWN_IDLE;
        end else begin
            acc     <= acc_n;
            bank    <= bank_n;
            prev_s  <= S;
            RAS     <= ras_n;
            cas_q   <= cas_n;
            CASel   <= casel_n;
            CopyAck <= ack_n;
            Owner   <= (ras_n || (cas_n != 2'b00)) ? owner_of(acc_n) : OWN_IDLE;
        end
    end

endmodule

// File: doc/dram_sched.md
DRAM_SCHED -- requirements
Module: dram_sched

Interface
- REQ-001 Parameter REF_PERIOD, default 13: Apple bus cycles between refresh requests.
- REQ-002 Parameter REF_MAX_PEND, default 4: saturation limit of the pending-refresh count.
- REQ-003 C7M  in  1  clock, 7.16 MHz; all logic is on the rising edge.
- REQ-004 RES  in  1  reset, asynchronous, active-high.
- REQ-005 S  in  3  Apple bus state. 1..7 means synced; 0 means not yet synced.
- REQ-006 CpuReq  in  1  Apple-side RAM register access this bus cycle.
- REQ-007 CpuWr  in  1  1 = write, 0 = read. Sampled with CpuReq.
- REQ-008 CpuBank  in  1  DRAM bank for the CPU access (address bit 22).
- REQ-009 CopyReq  in  1  copy-engine request. Level; held until CopyAck.
- REQ-010 CopyBank  in  1  DRAM bank for the copy access.
- REQ-011 CopyAck  out  1  one-cycle pulse when a copy access completes.
- REQ-012 RAS, CAS0, CAS1  out  1 each  active-high strobes; the top level inverts them at the pins.
- REQ-013 CASel  out  1  address mux select: 0 = row, 1 = column.
- REQ-014 Owner  out  2  current DRAM owner: 00 idle, 01 cpu, 10 refresh, 11 copy.
- REQ-015 RefPend  out  1  pending-refresh count is nonzero.

Function
- REQ-016 Bus cycle split into two windows:
  - background window S1..S3: refresh or copy;
  - CPU window S4..S7.
  - No DRAM cycle spans a window boundary.
- REQ-017 Refresh counter:
  - counts S==3 cycles and wraps at REF_PERIOD-1;
  - on the wrap cycle, pending count increments, saturating at REF_MAX_PEND.
- REQ-018 Background arbitration happens at S==1: refresh wins if pending; otherwise copy if CopyReq; otherwise idle.
- REQ-019 Refresh (CAS-before-RAS):
  - CAS0 and CAS1 high in S1..S3; RAS high in S2..S3;
  - all three low on the first cycle of S4;
  - pending count decrements at S==3.
- REQ-020 Copy:
  - RAS high in S1..S3 with CASel=0 in S1;
  - CASel=1 and CAS(CopyBank) high in S2..S3;
  - CopyAck pulses on the S==3 cycle.
- REQ-021 CPU read (CpuReq & ~CpuWr sampled at S==4):
  - RAS and CASel high in S5..S7;
  - CAS(CpuBank) high in S6..S7.
- REQ-022 CPU write (CpuReq & CpuWr sampled at S==4):
  - RAS and CASel high in S6..S7;
  - CAS(CpuBank) high in S7 only.
- REQ-023 All CPU strobes deassert on the cycle S becomes 1 (precharge). The CPU never waits; its window is reserved.
- REQ-024 Owner reflects the access whose strobes are asserted; it is 00 whenever RAS, CAS0 and CAS1 are all low.
- REQ-025 S==0: no accesses are issued; refresh pending still accumulates.
- REQ-026 Resync, i.e. S jumps to 1 out of sequence:
  - the current access aborts and all strobes go low next cycle;
  - an aborted copy gives no CopyAck and is retried;
  - an aborted refresh does not decrement the pending count.
- REQ-027 CopyReq dropped before ack: copy not started at next S==1; an in-progress copy completes.
- REQ-028 At most one of CAS0/CAS1 is high except during refresh.

Reset
- REQ-029 RES high: RAS=CAS0=CAS1=CASel=0, CopyAck=0, Owner=00, RefPend=0, pending=0, period counter=0, immediately and asynchronously.
- REQ-030 RES asserted mid-access: the access is dropped with no ack. Normal arbitration resumes at the first S==1 after release.

Configuration
- REQ-031 Macro DRAM_SCHED_COPY_EN:
  - defined: copy port arbitrated as above;
  - undefined: CopyReq/CopyBank ignored, CopyAck tied 0, Owner never 11, background window used only for refresh.

Structure
- REQ-032 The shared package gr8ram_pkg holds:
  - the Owner encoding constants;
  - the bus-state constants S_UNSYNC=0 and S1..S7;
  - defaults for REF_PERIOD and REF_MAX_PEND.
- REQ-033 Sub-module dram_ref_ctr holds the period counter and the saturating pending count. Inputs: C7M, RES, tick (S==3), dec. Outputs: pending nonzero, pending count.

Verification
- REQ-034 CPU read, CpuBank=1, at S4: RAS and CASel high S5..S7, CAS1 high S6..S7, CAS0 low throughout, all low at S1, Owner=01 during S5..S7.
- REQ-035 CPU write, CpuBank=0: RAS high S6..S7, CAS0 high S7 only, low at S1.
- REQ-036 Hold S==0 for 60 bus-cycle equivalents (S3 ticks forced), then sync:
  - RefPend=1, pending saturates at 4;
  - four consecutive background windows are refresh (CAS0=CAS1=1 before RAS);
  - the fifth window serves a held CopyReq with a single CopyAck.
- REQ-037 CopyReq held with refresh due in the same S1: refresh first, copy in the next bus cycle, CopyAck exactly once at S3.
- REQ-038 Force S to 1 during a copy at S2: strobes low next cycle, no CopyAck; copy reissued at the following S1 and acked.
- REQ-039 Assert RES during a CPU read at S6: outputs 0 immediately. Build without DRAM_SCHED_COPY_EN: CopyReq=1 gives CopyAck=0 and Owner never 11.
